// File: rtl/perf_pkg.sv
// Shared definitions for the pipeline performance monitor.
// Counter index map: the fixed event counters come first, and the
// programmable opcode-match counters start at OPC_BASE.
package perf_pkg;

  localparam int CYCLE    = 0;
  localparam int RETIRE   = 1;
  localparam int HAZARD   = 2;
  localparam int OPC_BASE = 3;

  // Width of a select field for n entries. A single entry still needs a 1-bit port.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/perf_counter.sv
// Single event counter with a synchronous clear and a sticky overflow flag.
// SATURATE != 0 makes the counter stick at all-ones. SATURATE == 0 makes it wrap to zero.
// In both modes an increment while at all-ones sets ovf.
module perf_counter
  import perf_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] value,
  output logic             ovf
);

  logic [CNT_W-1:0] cnt_r;
  logic             ovf_r;
  logic             at_max_s;

  assign at_max_s = &cnt_r;
  assign value    = cnt_r;
  assign ovf      = ovf_r;

  // Count register: clear beats increment; all-ones either holds or wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
      ovf_r <= 1'b0;
    end else if (clr) begin
      cnt_r <= '0;
      ovf_r <= 1'b0;
    end else if (inc) begin
      if (at_max_s) begin
        ovf_r <= 1'b1;
        cnt_r <= (SATURATE != 0) ? cnt_r : '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pipe_perf_monitor.sv
// Pipeline performance monitor: cycle, retire, hazard and per-opcode retire
// counters, with a one-cycle-latency read port.
// Optional feature macro PERF_MON_SNAPSHOT_EN adds a 'snap' input. That input copies
// every live counter into a shadow bank, and reads are then served from the shadow bank.
module pipe_perf_monitor
  import perf_pkg::*;
#(
  parameter  int CNT_W    = 32,
  parameter  int OPCODE_W = 4,
  parameter  int NUM_OPC  = 4,
  parameter  int SATURATE = 1,
  localparam int NUM_CNT  = OPC_BASE + NUM_OPC,
  localparam int IDX_W    = $clog2(NUM_CNT),
  localparam int SEL_W    = sel_width(NUM_OPC)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr,
  input  logic                is_hazard,
  input  logic                retire_valid,
  input  logic [OPCODE_W-1:0] retire_opcode,
  input  logic                cfg_we,
  input  logic [SEL_W-1:0]    cfg_sel,
  input  logic [OPCODE_W-1:0] cfg_opcode,
  input  logic                rd_req,
  input  logic [IDX_W-1:0]    rd_idx,
`ifdef PERF_MON_SNAPSHOT_EN
  input  logic                snap,
`endif
  output logic                rd_valid,
  output logic                rd_err,
  output logic [CNT_W-1:0]    rd_data,
  output logic [NUM_CNT-1:0]  ovf
);

  logic [OPCODE_W-1:0] match_r   [NUM_OPC];
  logic [NUM_CNT-1:0]  inc_s;
  logic [CNT_W-1:0]    cnt_val_s [NUM_CNT];
  logic [CNT_W-1:0]    rd_src_s  [NUM_CNT];
  logic [NUM_CNT-1:0]  ovf_s;
  logic                rd_hit_s;
  logic [CNT_W-1:0]    rd_sel_s;
  logic                rd_valid_r;
  logic                rd_err_r;
  logic [CNT_W-1:0]    rd_data_r;

  // Match opcodes: reset to the counter's own index. A write lands at the edge,
  // so a retire in the same cycle still compares against the old value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_OPC; k++) begin
        match_r[k] <= OPCODE_W'(k);
      end
    end else if (cfg_we) begin
      for (int k = 0; k < NUM_OPC; k++) begin
        if (cfg_sel == SEL_W'(k)) begin
          match_r[k] <= cfg_opcode;
        end
      end
    end
  end

  // Increment requests for every counter, all gated by the global enable.
  always_comb begin
    inc_s         = '0;
    inc_s[CYCLE]  = en;
    inc_s[RETIRE] = en & retire_valid;
    inc_s[HAZARD] = en & is_hazard;
    for (int k = 0; k < NUM_OPC; k++) begin
      inc_s[OPC_BASE+k] = en & retire_valid & (retire_opcode == match_r[k]);
    end
  end

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    perf_counter #(
      .CNT_W   (CNT_W),
      .SATURATE(SATURATE)
    ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .inc  (inc_s[i]),
      .value(cnt_val_s[i]),
      .ovf  (ovf_s[i])
    );
  end

  assign ovf = ovf_s;

`ifdef PERF_MON_SNAPSHOT_EN
  logic [CNT_W-1:0] shadow_r [NUM_CNT];

  // Shadow bank: captures the live values as they were before this edge.
  // A snap in the same cycle as clr therefore keeps the pre-clear values. clr never touches this bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        shadow_r[i] <= '0;
      end
    end else if (snap) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        shadow_r[i] <= cnt_val_s[i];
      end
    end
  end

  // Reads are served from the shadow bank.
  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) begin
      rd_src_s[i] = shadow_r[i];
    end
  end
`else
  // Reads are served from the live counters, before this cycle's update.
  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) begin
      rd_src_s[i] = cnt_val_s[i];
    end
  end
`endif

  // Read select: the OR of the masked entries. No entry matches when the index is out of range.
  always_comb begin
    rd_hit_s = 1'b0;
    rd_sel_s = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      rd_hit_s = rd_hit_s | (rd_idx == IDX_W'(i));
      rd_sel_s = rd_sel_s | ({CNT_W{rd_idx == IDX_W'(i)}} & rd_src_s[i]);
    end
  end

  // Read response register: one-cycle latency. Data and err are forced to zero whenever no response is issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_r <= 1'b0;
      rd_err_r   <= 1'b0;
      rd_data_r  <= '0;
    end else begin
      rd_valid_r <= rd_req;
      if (rd_req) begin
        rd_err_r  <= ~rd_hit_s;
        rd_data_r <= rd_hit_s ? rd_sel_s : '0;
      end else begin
        rd_err_r  <= 1'b0;
        rd_data_r <= '0;
      end
    end
  end

  assign rd_valid = rd_valid_r;
  assign rd_err   = rd_err_r;
  assign rd_data  = rd_data_r;

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Testbench for pipe_perf_monitor. Three instances share the stimulus:
// one uses the default 32-bit counters, and two use 8-bit counters (one saturating, one wrapping).
// The reference model keeps an unbounded event count per counter.
// Each instance's expected value is derived from that count by clamping or by taking it modulo 2^W.
module tb_pipe_perf_monitor;

  localparam int NUM_CNT = 7;

  logic       clk, rst, en, clr, is_hazard, retire_valid, cfg_we, rd_req, snap;
  logic [3:0] retire_opcode, cfg_opcode;
  logic [1:0] cfg_sel;
  logic [2:0] rd_idx;

  logic        rv_m, re_m, rv_s, re_s, rv_w, re_w;
  logic [31:0] rd_m;
  logic [7:0]  rd_s, rd_w;
  logic [6:0]  ovf_m, ovf_s, ovf_w;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  longint unsigned cnt_n    [NUM_CNT];
  longint unsigned shadow_n [NUM_CNT];
  logic [3:0]      match_m  [4];
  logic            exp_valid, exp_err;
  logic [31:0]     exp_m;
  logic [7:0]      exp_s, exp_w;

  pipe_perf_monitor u_dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .is_hazard(is_hazard),
    .retire_valid(retire_valid), .retire_opcode(retire_opcode),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_opcode(cfg_opcode),
    .rd_req(rd_req), .rd_idx(rd_idx),
`ifdef PERF_MON_SNAPSHOT_EN
    .snap(snap),
`endif
    .rd_valid(rv_m), .rd_err(re_m), .rd_data(rd_m), .ovf(ovf_m)
  );

  pipe_perf_monitor #(.CNT_W(8), .SATURATE(1)) u_sat8 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .is_hazard(is_hazard),
    .retire_valid(retire_valid), .retire_opcode(retire_opcode),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_opcode(cfg_opcode),
    .rd_req(rd_req), .rd_idx(rd_idx),
`ifdef PERF_MON_SNAPSHOT_EN
    .snap(snap),
`endif
    .rd_valid(rv_s), .rd_err(re_s), .rd_data(rd_s), .ovf(ovf_s)
  );

  pipe_perf_monitor #(.CNT_W(8), .SATURATE(0)) u_wrap8 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .is_hazard(is_hazard),
    .retire_valid(retire_valid), .retire_opcode(retire_opcode),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_opcode(cfg_opcode),
    .rd_req(rd_req), .rd_idx(rd_idx),
`ifdef PERF_MON_SNAPSHOT_EN
    .snap(snap),
`endif
    .rd_valid(rv_w), .rd_err(re_w), .rd_data(rd_w), .ovf(ovf_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A counter that has seen n events: clamps or wraps once n exceeds 2^w-1.
  function automatic longint unsigned mval(longint unsigned n, int w, bit sat);
    longint unsigned mx;
    mx = (64'd1 << w) - 64'd1;
    if (n <= mx) return n;
    if (sat) return mx;
    return n % (mx + 64'd1);
  endfunction

  function automatic logic [6:0] oexp(int w);
    logic [6:0] r;
    for (int i = 0; i < NUM_CNT; i++) r[i] = (cnt_n[i] > ((64'd1 << w) - 64'd1));
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_n[i]    = 0;
      shadow_n[i] = 0;
    end
    for (int k = 0; k < 4; k++) match_m[k] = 4'(k);
  endtask

  // One clock: predict the read response from the pre-edge state, then apply the event rules.
  task automatic step();
    longint unsigned src;
    bit use_shadow;
    use_shadow = 1'b0;
`ifdef PERF_MON_SNAPSHOT_EN
    use_shadow = 1'b1;
`endif
    exp_valid = rd_req;
    exp_err   = rd_req && (int'(rd_idx) >= NUM_CNT);
    src = 0;
    if (rd_req && !exp_err) src = use_shadow ? shadow_n[rd_idx] : cnt_n[rd_idx];
    exp_m = 32'(mval(src, 32, 1'b1));
    exp_s = 8'(mval(src, 8, 1'b1));
    exp_w = 8'(mval(src, 8, 1'b0));
    @(posedge clk);
`ifdef PERF_MON_SNAPSHOT_EN
    if (snap) for (int i = 0; i < NUM_CNT; i++) shadow_n[i] = cnt_n[i];
`endif
    if (clr) begin
      for (int i = 0; i < NUM_CNT; i++) cnt_n[i] = 0;
    end else if (en) begin
      cnt_n[0]++;
      if (retire_valid) cnt_n[1]++;
      if (is_hazard) cnt_n[2]++;
      for (int k = 0; k < 4; k++)
        if (retire_valid && retire_opcode == match_m[k]) cnt_n[3+k]++;
    end
    if (cfg_we) match_m[cfg_sel] = cfg_opcode;
    #1;
  endtask

  // In the shadow-bank build, copy the live counters so that direct reads see them.
  task automatic sync_shadow();
`ifdef PERF_MON_SNAPSHOT_EN
    snap = 1'b1;
    step();
    snap = 1'b0;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; clr = 1'b0; is_hazard = 1'b0; retire_valid = 1'b0;
    retire_opcode = 4'd0; cfg_we = 1'b0; cfg_sel = 2'd0; cfg_opcode = 4'd0;
    rd_req = 1'b0; rd_idx = 3'd0; snap = 1'b0;
    model_reset();
    #2;
    n_cmp++;
    if ({rv_m, re_m, rd_m, ovf_m, rv_s, re_s, rd_s, ovf_s} !== 58'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rv=%b err=%b data=%0d ovf=%b want all zero", rv_m, re_m, rd_m, ovf_m);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    step();
    n_cmp++;
    if (rv_m !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_no_valid: got %b want 0", rv_m);
    end
  endtask

  task automatic test_cycle_count();
    en = 1'b1;
    repeat (10) step();
    en = 1'b0;
    sync_shadow();
    rd_req = 1'b1; rd_idx = 3'd0;
    step();
    rd_req = 1'b0;
    n_cmp++;
    if (rv_m !== 1'b1 || re_m !== 1'b0 || rd_m !== 32'd10) begin
      n_bad++;
      $display("FAIL cycle_read: got v=%b e=%b d=%0d want v=1 e=0 d=10", rv_m, re_m, rd_m);
    end
    step();
    n_cmp++;
    if (rv_m !== 1'b0 || rd_m !== 32'd0 || re_m !== 1'b0) begin
      n_bad++;
      $display("FAIL cycle_pulse: got v=%b d=%0d want v=0 d=0", rv_m, rd_m);
    end
  endtask

  task automatic test_opcode();
    logic [3:0] ops [6];
    int ridx [5];
    int rwant [5];
    ops = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd1, 4'd3};
    ridx = '{1, 4, 3, 5, 6};
    rwant = '{6, 3, 1, 1, 1};
    clr = 1'b1; step(); clr = 1'b0;
    en = 1'b1; retire_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      retire_opcode = ops[i];
      step();
    end
    en = 1'b0; retire_valid = 1'b0;
    sync_shadow();
    rd_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rd_idx = 3'(ridx[i]);
      step();
      n_cmp++;
      if (rv_m !== 1'b1 || rd_m !== 32'(rwant[i])) begin
        n_bad++;
        $display("FAIL opcode_cnt%0d: got v=%b d=%0d want v=1 d=%0d", ridx[i], rv_m, rd_m, rwant[i]);
      end
    end
    rd_req = 1'b0;
  endtask

  task automatic test_cfg();
    clr = 1'b1; step(); clr = 1'b0;
    en = 1'b1; retire_valid = 1'b1; retire_opcode = 4'd0;
    cfg_we = 1'b1; cfg_sel = 2'd0; cfg_opcode = 4'd9;
    step();
    cfg_we = 1'b0; retire_opcode = 4'd9;
    step();
    retire_opcode = 4'd0;
    step();
    en = 1'b0; retire_valid = 1'b0;
    sync_shadow();
    rd_req = 1'b1; rd_idx = 3'd3;
    step();
    n_cmp++;
    if (rd_m !== 32'd2) begin
      n_bad++;
      $display("FAIL cfg_old_match: got %0d want 2", rd_m);
    end
    rd_idx = 3'd1;
    step();
    rd_req = 1'b0;
    n_cmp++;
    if (rd_m !== 32'd3) begin
      n_bad++;
      $display("FAIL cfg_retire_cnt: got %0d want 3", rd_m);
    end
  endtask

  task automatic test_saturate();
    clr = 1'b1; step(); clr = 1'b0;
    en = 1'b1; is_hazard = 1'b1;
    repeat (300) step();
    en = 1'b0; is_hazard = 1'b0;
    sync_shadow();
    rd_req = 1'b1; rd_idx = 3'd2;
    step();
    rd_req = 1'b0;
    n_cmp++;
    if (rd_s !== 8'd255 || ovf_s[2] !== 1'b1) begin
      n_bad++;
      $display("FAIL sat_hazard: got d=%0d ovf=%b want d=255 ovf2=1", rd_s, ovf_s);
    end
    n_cmp++;
    if (rd_w !== 8'd44 || ovf_w[2] !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_hazard: got d=%0d ovf=%b want d=44 ovf2=1", rd_w, ovf_w);
    end
    n_cmp++;
    if (rd_m !== 32'd300 || ovf_m !== 7'd0 || ovf_s[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL wide_hazard: got d=%0d ovf=%b s_ovf=%b want d=300 ovf=0 s_ovf1=0", rd_m, ovf_m, ovf_s);
    end
  endtask

  task automatic test_reset_midread();
    en = 1'b1; is_hazard = 1'b1; rd_req = 1'b1; rd_idx = 3'd2;
    #2 rst = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if ({rv_m, re_m, rd_m, ovf_m, rv_s, re_s, rd_s, ovf_s, ovf_w} !== 65'd0) begin
      n_bad++;
      $display("FAIL async_reset: got v=%b d=%0d ovf_s=%b ovf_w=%b want all zero", rv_m, rd_m, ovf_s, ovf_w);
    end
    @(posedge clk);
    #1;
    rst = 1'b1; rd_req = 1'b0; en = 1'b0; is_hazard = 1'b0;
    n_cmp++;
    if (rv_m !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_cancel: got v=%b want 0", rv_m);
    end
    step();
    n_cmp++;
    if (rv_m !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_cancel_late: got v=%b want 0", rv_m);
    end
    en = 1'b1; retire_valid = 1'b1; retire_opcode = 4'd3;
    step();
    retire_opcode = 4'd0;
    step();
    en = 1'b0; retire_valid = 1'b0;
    sync_shadow();
    rd_req = 1'b1; rd_idx = 3'd3;
    step();
    n_cmp++;
    if (rd_m !== 32'd1) begin
      n_bad++;
      $display("FAIL match0_reset: got %0d want 1", rd_m);
    end
    rd_idx = 3'd6;
    step();
    rd_req = 1'b0;
    n_cmp++;
    if (rd_m !== 32'd1) begin
      n_bad++;
      $display("FAIL match3_reset: got %0d want 1", rd_m);
    end
  endtask

  task automatic test_clr_read();
    en = 1'b1; is_hazard = 1'b1;
    repeat (260) step();
    is_hazard = 1'b0;
    n_cmp++;
    if (ovf_s[2] !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_clr_ovf: got %b want ovf2=1", ovf_s);
    end
    clr = 1'b1; step(); clr = 1'b0;
    repeat (20) step();
    en = 1'b0;
    sync_shadow();
    clr = 1'b1; en = 1'b1; rd_req = 1'b1; rd_idx = 3'd0;
    step();
    clr = 1'b0; rd_req = 1'b0;
    n_cmp++;
    if (rd_m !== 32'd20) begin
      n_bad++;
      $display("FAIL clr_read_pre: got %0d want 20", rd_m);
    end
    step();
    en = 1'b0;
    sync_shadow();
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    n_cmp++;
    if (rd_m !== 32'd1 || ovf_m !== 7'd0 || ovf_s !== 7'd0 || ovf_w !== 7'd0) begin
      n_bad++;
      $display("FAIL clr_read_post: got d=%0d ovf_s=%b ovf_w=%b want d=1 ovf=0", rd_m, ovf_s, ovf_w);
    end
  endtask

  task automatic test_bad_idx();
    rd_req = 1'b1; rd_idx = 3'd7;
    step();
    n_cmp++;
    if (rv_m !== 1'b1 || re_m !== 1'b1 || rd_m !== 32'd0 || re_s !== 1'b1 || rd_s !== 8'd0) begin
      n_bad++;
      $display("FAIL bad_idx: got v=%b e=%b d=%0d want v=1 e=1 d=0", rv_m, re_m, rd_m);
    end
    rd_idx = 3'd1;
    step();
    n_cmp++;
    if (rv_m !== 1'b1 || re_m !== 1'b0) begin
      n_bad++;
      $display("FAIL good_idx_err: got v=%b e=%b want v=1 e=0", rv_m, re_m);
    end
    rd_req = 1'b0; rd_idx = 3'd7;
    step();
    n_cmp++;
    if (rv_m !== 1'b0 || re_m !== 1'b0 || rd_m !== 32'd0) begin
      n_bad++;
      $display("FAIL idle_read: got v=%b e=%b d=%0d want all 0", rv_m, re_m, rd_m);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      en            = ($urandom_range(0, 3) != 0);
      retire_valid  = $urandom_range(0, 1);
      retire_opcode = 4'($urandom_range(0, 5));
      is_hazard     = $urandom_range(0, 1);
      cfg_we        = ($urandom_range(0, 15) == 0);
      cfg_sel       = 2'($urandom_range(0, 3));
      cfg_opcode    = 4'($urandom_range(0, 5));
      clr           = ($urandom_range(0, 127) == 0);
      rd_req        = $urandom_range(0, 1);
      rd_idx        = 3'($urandom_range(0, 7));
`ifdef PERF_MON_SNAPSHOT_EN
      snap          = ($urandom_range(0, 15) == 0);
`endif
      step();
      n_cmp++;
      if ({rv_m, re_m, rd_m} !== {exp_valid, exp_err, exp_m}) begin
        n_bad++;
        $display("FAIL rand_rd_wide c=%0d: got v=%b e=%b d=%0d want v=%b e=%b d=%0d",
                 c, rv_m, re_m, rd_m, exp_valid, exp_err, exp_m);
      end
      n_cmp++;
      if ({rv_s, re_s, rd_s, rd_w} !== {exp_valid, exp_err, exp_s, exp_w}) begin
        n_bad++;
        $display("FAIL rand_rd_8 c=%0d: got s=%0d w=%0d want s=%0d w=%0d", c, rd_s, rd_w, exp_s, exp_w);
      end
      n_cmp++;
      if (ovf_m !== oexp(32) || ovf_s !== oexp(8) || ovf_w !== oexp(8)) begin
        n_bad++;
        $display("FAIL rand_ovf c=%0d: got m=%b s=%b w=%b want m=%b s8=%b", c, ovf_m, ovf_s, ovf_w, oexp(32), oexp(8));
      end
    end
    en = 1'b0; retire_valid = 1'b0; is_hazard = 1'b0; cfg_we = 1'b0;
    clr = 1'b0; rd_req = 1'b0; snap = 1'b0;
  endtask

`ifdef PERF_MON_SNAPSHOT_EN
  task automatic test_snapshot();
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    en = 1'b1;
    repeat (15) step();
    snap = 1'b1; step(); snap = 1'b0;
    repeat (10) step();
    en = 1'b0; rd_req = 1'b1; rd_idx = 3'd0;
    step();
    rd_req = 1'b0;
    n_cmp++;
    if (rd_m !== 32'd15) begin
      n_bad++;
      $display("FAIL snap_read: got %0d want 15", rd_m);
    end
    snap = 1'b1; clr = 1'b1;
    step();
    snap = 1'b0; clr = 1'b0; rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    n_cmp++;
    if (rd_m !== 32'd26) begin
      n_bad++;
      $display("FAIL snap_clr: got %0d want 26", rd_m);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_cycle_count();
    test_opcode();
    test_cfg();
    test_saturate();
    test_reset_midread();
    test_clr_read();
    test_bad_idx();
    test_random();
`ifdef PERF_MON_SNAPSHOT_EN
    test_snapshot();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_perf_monitor.md
PIPE_PERF_MONITOR -- requirements
Module: pipe_perf_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 32, counter width in bits (range 8..64).
REQ-002 SHALL have parameter OPCODE_W, default 4, width of the retired-instruction opcode.
REQ-003 SHALL have parameter NUM_OPC, default 4, number of programmable opcode-match counters (1..8); total counters NUM_CNT = 3 + NUM_OPC, index width IDX_W = clog2(NUM_CNT).
REQ-004 SHALL have parameter SATURATE, default 1; 1 = saturate, 0 = wrap.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  global count enable.
REQ-008 clr  input  1  synchronous clear of all counters and overflow flags.
REQ-009 is_hazard  input  1  pipeline stall/hazard this cycle.
REQ-010 retire_valid  input  1  one instruction retires this cycle.
REQ-011 retire_opcode  input  OPCODE_W  opcode of the retiring instruction.
REQ-012 cfg_we, cfg_sel, cfg_opcode  input  1 / clog2(NUM_OPC) / OPCODE_W  write match opcode of opcode counter cfg_sel.
REQ-013 rd_req, rd_idx  input  1 / IDX_W  read request and counter index.
REQ-014 rd_valid, rd_err, rd_data  output  1 / 1 / CNT_W  read response.
REQ-015 ovf  output  NUM_CNT  sticky per-counter overflow flags.

Function
REQ-016 Counter 0 SHALL increment every cycle with en=1; counter 1 on en & retire_valid; counter 2 on en & is_hazard; counter 3+k on en & retire_valid & (retire_opcode == match[k]).
REQ-017 With en=0 all counters SHALL hold; clr, cfg and reads still operate.
REQ-018 clr SHALL take priority over increment: counters and ovf are 0 after the clr edge, no increment that cycle.
REQ-019 SATURATE=1: a counter at all-ones SHALL stay all-ones on a further increment and set its ovf bit.
REQ-020 SATURATE=0: a counter at all-ones SHALL wrap to 0 on increment and set its ovf bit.
REQ-021 ovf bits SHALL stay set until clr or reset.
REQ-022 Read latency SHALL be exactly 1 cycle: rd_valid pulses high for one cycle after each cycle with rd_req=1; back-to-back requests give back-to-back responses.
REQ-023 rd_data SHALL be the counter value before that cycle's update (pre-increment, pre-clear).
REQ-024 rd_idx >= NUM_CNT SHALL give rd_data=0 and rd_err=1 with rd_valid; otherwise rd_err=0.
REQ-025 rd_data and rd_err SHALL be 0 whenever rd_valid=0.
REQ-026 cfg_we SHALL update match[cfg_sel] at the edge; a retire in the same cycle SHALL compare against the old match value.

Reset
REQ-027 On rst low, all counters, ovf, rd_valid, rd_err, rd_data SHALL be 0 immediately; match[k] SHALL reset to k.
REQ-028 Reset mid-read SHALL cancel the pending response (no rd_valid after release).

Configuration
REQ-029 Macro PERF_MON_SNAPSHOT_EN defined: input snap (1 bit) added; snap copies all live counters to a shadow bank in one edge, reads return shadow values, shadow resets to 0, clr does not clear shadow; snap and clr together capture pre-clear values.
REQ-030 Macro undefined: no snap port, no shadow bank, reads return live counters per REQ-023.

Structure
REQ-031 Counter index constants (CYCLE=0, RETIRE=1, HAZARD=2, OPC_BASE=3) SHALL live in shared package perf_pkg.
REQ-032 One sub-module perf_counter (single CNT_W counter with inc, clr, saturate/wrap, ovf) SHALL be instantiated NUM_CNT times.

Verification
REQ-033 Reset, en=1 for 10 cycles, rd_idx=0 -> rd_data=10 one cycle later, rd_valid=1 for one cycle.
REQ-034 retire_valid for 6 cycles with opcodes 0,1,1,2,1,3 (default match) -> counter 1 = 6, counter 4 = 3, counter 3 = 1.
REQ-035 CNT_W=8, SATURATE=1, is_hazard held 300 cycles -> counter 2 = 255, ovf[2]=1; SATURATE=0 -> counter 2 = 44, ovf[2]=1.
REQ-036 clr and rd_req(idx 0, value 20) in same cycle -> rd_data=20; next read = 1 with ovf=0.
REQ-037 rd_idx=NUM_CNT -> rd_valid=1, rd_err=1, rd_data=0.
REQ-038 PERF_MON_SNAPSHOT_EN: snap at cycle count 15, run 10 more, read idx 0 -> 15; rst low mid-read -> no rd_valid.
